// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: L1<->L2 request/response structs and the
// arbiter state/grant enums.
package mem_pkg;

  localparam int BLOCK_BITS = 128;

  typedef struct packed {
    logic                  Valid;
    logic                  Wen;
    logic [31:0]           Addr;
    logic [BLOCK_BITS-1:0] BlockData;
  } CacheToMem_t;

  typedef struct packed {
    logic                  Ready;
    logic [BLOCK_BITS-1:0] BlockData;
  } MemToCache_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } ArbState_t;

  typedef enum logic {
    DAT = 1'b0,
    INS = 1'b1
  } Grant_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin selector: on contention the side that
// did not win last time is picked.
module rr_pick2
  import mem_pkg::*;
(
  input  logic   req_d,
  input  logic   req_i,
  input  Grant_t last_grant,
  output logic   gnt_valid,
  output Grant_t gnt
);

  // NOTE: every output gets a value on every path of always_comb, otherwise
  // synthesis infers a latch to hold the unassigned case.
  always_comb begin
    gnt_valid = req_d | req_i;
    if (req_d && req_i) begin
      gnt = (last_grant == DAT) ? INS : DAT;
    end else if (req_d) begin
      gnt = DAT;
    end else begin
      gnt = INS;
    end
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Registered round-robin arbiter between L1 data and L1 instruction caches
// and the shared L2: latches the winning request, holds it until L2 Ready.
module l1_l2_arbiter
  import mem_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  CacheToMem_t l1Dat_i,
  input  CacheToMem_t l1Ins_i,
  input  MemToCache_t L2Out_i,
  output MemToCache_t l1Dat_o,
  output MemToCache_t l1Ins_o,
  output CacheToMem_t L2In_o,
  output logic [15:0] conflicts_o
);

  ArbState_t             state_q;
  Grant_t                last_grant_q;
  CacheToMem_t           req_q;
  logic [BLOCK_BITS-1:0] resp_q;
  logic [15:0]           conflicts_q;

  CacheToMem_t           ins_req;
  logic                  gnt_valid;
  Grant_t                gnt;

  // The instruction side may never write L2.
  always_comb begin
    ins_req     = l1Ins_i;
    ins_req.Wen = 1'b0;
  end

  rr_pick2 u_pick (
    .req_d      (l1Dat_i.Valid),
    .req_i      (l1Ins_i.Valid),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // last_grant_q doubles as the owner of the in-flight transaction.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= INS;
      req_q        <= '0;
      resp_q       <= '0;
      conflicts_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (l1Dat_i.Valid && l1Ins_i.Valid && (conflicts_q != 16'hFFFF)) begin
            conflicts_q <= conflicts_q + 16'd1;
          end
          if (gnt_valid) begin
            req_q        <= (gnt == DAT) ? l1Dat_i : ins_req;
            last_grant_q <= gnt;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (L2Out_i.Ready) begin
            resp_q  <= L2Out_i.BlockData;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes decode from the state register so reset clears them at once.
  always_comb begin
    L2In_o             = req_q;
    L2In_o.Valid       = (state_q == BUSY);
    l1Dat_o.Ready      = (state_q == RESP) && (last_grant_q == DAT);
    l1Dat_o.BlockData  = resp_q;
    l1Ins_o.Ready      = (state_q == RESP) && (last_grant_q == INS);
    l1Ins_o.BlockData  = resp_q;
  end

  assign conflicts_o = conflicts_q;

endmodule
